// File: rtl/skid_register_pkg.sv
// -----------------------------------------------------------------------------
// skid_register_pkg
// Shared definitions for the elastic (valid/ready) pipeline stages.
//   skid_state_t  : occupancy state of a one-entry-skid elastic stage
//                   EMPTY = nothing held, ONE = main register full,
//                   FULL = main and skid registers both full
//   handshakeFire : a transfer happens when valid and ready are both high
// -----------------------------------------------------------------------------
package skid_register_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  function automatic logic handshakeFire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/skid_register_en_reg.sv
// -----------------------------------------------------------------------------
// skid_register_en_reg
// Plain enable register used as word storage inside the elastic stage.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high; loads INIT
//   i_en   : load strobe
//   i_d    : data to load
//   o_q    : stored data
// -----------------------------------------------------------------------------
module skid_register_en_reg #(
  parameter int unsigned        WIDTH = 8,
  parameter logic [WIDTH-1:0]   INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= INIT;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/skid_register.sv
// -----------------------------------------------------------------------------
// skid_register
// Elastic single-stage pipeline register with a one-entry skid buffer.
// Data, valid and ready are all registered so no combinational path crosses
// the stage; full throughput is one word per cycle with one cycle of latency.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   in_data   : upstream data
//   in_valid  : upstream word present
//   in_ready  : stage can accept a word (registered)
//   out_data  : downstream data (registered)
//   out_valid : out_data holds a word (registered)
//   out_ready : downstream accepts the word
// -----------------------------------------------------------------------------
module skid_register
  import skid_register_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(3)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_t      r_state;
  skid_state_t      w_nextState;
  logic             r_inReady;
  logic             r_outValid;

  logic             w_inFire;
  logic             w_outFire;
  logic             w_loadMain;
  logic             w_loadSkid;
  logic             w_mainFromSkid;
  logic [WIDTH-1:0] w_mainD;
  logic [WIDTH-1:0] w_mainQ;
  logic [WIDTH-1:0] w_skidQ;

  assign w_inFire  = handshakeFire(in_valid, r_inReady);
  assign w_outFire = handshakeFire(r_outValid, out_ready);

  // Next-state and load strobes. Main always holds the oldest word, so when
  // the stage drains from FULL the skid word moves into main, keeping order.
  always_comb begin
    w_nextState    = r_state;
    w_loadMain     = 1'b0;
    w_loadSkid     = 1'b0;
    w_mainFromSkid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_inFire) begin
          w_nextState = ONE;
          w_loadMain  = 1'b1;
        end
      end
      ONE: begin
        if (w_inFire && w_outFire) begin
          w_loadMain = 1'b1;
        end else if (w_inFire) begin
          w_nextState = FULL;
          w_loadSkid  = 1'b1;
        end else if (w_outFire) begin
          w_nextState = EMPTY;
        end
      end
      FULL: begin
        if (w_outFire) begin
          w_nextState    = ONE;
          w_loadMain     = 1'b1;
          w_mainFromSkid = 1'b1;
        end
      end
      // Unused encoding 2'b11 drops back to a clean empty stage.
      default: begin
        w_nextState = EMPTY;
      end
    endcase
  end

  // Valid and ready are registered copies of the next-state occupancy, so
  // both outputs come straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= (w_nextState != FULL);
      r_outValid <= (w_nextState != EMPTY);
    end
  end

  assign w_mainD = w_mainFromSkid ? w_skidQ : in_data;

  skid_register_en_reg #(
    .WIDTH (WIDTH),
    .INIT  (INIT)
  ) u_mainReg (
    .clock (clock),
    .reset (reset),
    .i_en  (w_loadMain),
    .i_d   (w_mainD),
    .o_q   (w_mainQ)
  );

  skid_register_en_reg #(
    .WIDTH (WIDTH),
    .INIT  (INIT)
  ) u_skidReg (
    .clock (clock),
    .reset (reset),
    .i_en  (w_loadSkid),
    .i_d   (in_data),
    .o_q   (w_skidQ)
  );

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = w_mainQ;

endmodule
